// File: rtl/dmem_mmio_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder_pkg
//   Shared definitions for the data-memory responder: MMIO register offsets,
//   STATUS word bit positions, drop counter ceiling, and the decode region
//   type used by the top level.
// ---------------------------------------------------------------------------
package dmem_mmio_responder_pkg;

    localparam int unsigned DATA_W = 32;

    // Word offsets inside the 4-word MMIO window
    typedef enum logic [1:0] {
        MMIO_CYCLE  = 2'd0,
        MMIO_TXDATA = 2'd1,
        MMIO_STATUS = 2'd2,
        MMIO_DROP   = 2'd3
    } mmio_reg_e;

    // Address decode result for the current access
    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_BAD  = 2'd2
    } region_e;

    localparam int STATUS_FULL_BIT  = 31;
    localparam int STATUS_EMPTY_BIT = 30;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // STATUS = {full, empty, 14'b0, count[15:0]}
    function automatic logic [DATA_W-1:0] status_word(input logic        full,
                                                      input logic        empty,
                                                      input logic [15:0] count);
        logic [DATA_W-1:0] w;
        w                   = '0;
        w[STATUS_FULL_BIT]  = full;
        w[STATUS_EMPTY_BIT] = empty;
        w[15:0]             = count;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder_if
//   Bundles the processor data-memory port and the TX stream towards the
//   consumer.
//   address_dmem/data/wren : processor -> responder (word address, store data, store enable)
//   q_dmem                 : responder -> processor (registered load data)
//   tx_valid/tx_data       : responder -> consumer (FIFO head)
//   tx_ready               : consumer  -> responder (head accepted)
//   master : processor/consumer side     slave : responder side
// ---------------------------------------------------------------------------
interface dmem_mmio_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;

    modport master (
        output address_dmem, data, wren, tx_ready,
        input  q_dmem, tx_valid, tx_data
    );

    modport slave (
        input  address_dmem, data, wren, tx_ready,
        output q_dmem, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder_tx_fifo
//   Small flop-based FIFO holding words written to TXDATA. All state updates
//   on the falling edge of clock; reset is asynchronous, active-low.
//   clock, reset        : clock / async active-low reset
//   push, push_data     : write request and word
//   pop_req             : consumer ready (pop happens only when not empty)
//   full, empty, count  : occupancy (pre-edge state)
//   dropped             : push refused this edge (full with no pop)
//   head_valid/head_data: registered head of queue
// ---------------------------------------------------------------------------
module dmem_mmio_responder_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop_req,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             dropped,
    output logic             head_valid,
    output logic [31:0]      head_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0]      entry_q [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign pop_ok  = pop_req & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dropped = push & ~push_ok;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (pop_ok)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push_ok)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entries are cleared on reset so tx_data reads 0 after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] entry_reg;
            always_ff @(negedge clock or negedge reset) begin
                if (!reset)
                    entry_reg <= '0;
                else if (push_ok && (wr_ptr_reg == PTR_W'(gi)))
                    entry_reg <= push_data;
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Head comes straight from flops; a push into an empty FIFO is visible
    // only after the edge that stores it.
    assign head_valid = ~empty;
    assign head_data  = entry_q[rd_ptr_reg];

endmodule

// File: rtl/dmem_mmio_responder.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder
//   Responder for the processor data-memory port: word-addressed RAM plus a
//   4-word MMIO window (cycle counter, TX FIFO push, status, drop counter).
//   Everything samples on the FALLING edge so load data is ready before the
//   processor's next rising edge.
//   clock      : master clock (falling-edge active)
//   reset      : asynchronous, active-low
//   bus        : slave side of dmem_mmio_responder_if (dmem port + TX stream)
//   bad_access : sticky flag, set by any access outside RAM and MMIO window
// ---------------------------------------------------------------------------
module dmem_mmio_responder #(
    parameter int          ADDR_BITS  = 12,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h0000FFF0
) (
    input  logic                   clock,
    input  logic                   reset,
    dmem_mmio_responder_if.slave   bus,
    output logic                   bad_access
);
    import dmem_mmio_responder_pkg::*;

    localparam int RAM_DEPTH = 2 ** ADDR_BITS;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    // ---------------- address decode ----------------
    logic [31:0]          mmio_off_full;
    logic                 is_mmio;
    logic                 is_ram;
    region_e              region;
    mmio_reg_e            mmio_sel;
    logic [ADDR_BITS-1:0] ram_addr;

    assign mmio_off_full = bus.address_dmem - MMIO_BASE;
    assign is_mmio       = (mmio_off_full[31:2] == '0);
    assign is_ram        = (bus.address_dmem[31:ADDR_BITS] == '0);
    assign mmio_sel      = mmio_reg_e'(mmio_off_full[1:0]);
    assign ram_addr      = bus.address_dmem[ADDR_BITS-1:0];

    // The MMIO window wins if a large ADDR_BITS ever makes it overlap RAM.
    always_comb begin
        region = REGION_BAD;
        if (is_mmio)
            region = REGION_MMIO;
        else if (is_ram)
            region = REGION_RAM;
    end

    // ---------------- TX FIFO ----------------
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_dropped;

    assign fifo_push = bus.wren && (region == REGION_MMIO) && (mmio_sel == MMIO_TXDATA);

    dmem_mmio_responder_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (bus.data),
        .pop_req    (bus.tx_ready),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .dropped    (fifo_dropped),
        .head_valid (bus.tx_valid),
        .head_data  (bus.tx_data)
    );

    // ---------------- RAM (no reset, read-first) ----------------
    logic [31:0] ram [RAM_DEPTH];
    logic [31:0] ram_q_reg;
    logic        ram_we;

    // Stores presented while reset is held are discarded.
    assign ram_we = bus.wren && (region == REGION_RAM) && reset;

    always_ff @(negedge clock) begin
        if (ram_we)
            ram[ram_addr] <= bus.data;
        ram_q_reg <= ram[ram_addr];
    end

    // ---------------- MMIO registers ----------------
    logic [31:0] cycle_reg;
    logic [15:0] drop_reg, drop_next;
    logic        bad_access_reg;
    logic [31:0] mmio_q_reg;
    logic        rd_from_ram_reg;
    logic [31:0] mmio_rd_data;

    always_comb begin
        drop_next = drop_reg;
        if (bus.wren && (region == REGION_MMIO) && (mmio_sel == MMIO_DROP))
            drop_next = '0;
        else if (fifo_dropped && (drop_reg != DROP_MAX))
            drop_next = drop_reg + 16'd1;
    end

    // Reads return pre-edge state and have no side effects.
    always_comb begin
        mmio_rd_data = '0;
        case (mmio_sel)
            MMIO_CYCLE:  mmio_rd_data = cycle_reg;
            MMIO_TXDATA: mmio_rd_data = '0;
            MMIO_STATUS: mmio_rd_data = status_word(fifo_full, fifo_empty, 16'(fifo_count));
            MMIO_DROP:   mmio_rd_data = {16'h0000, drop_reg};
            default:     mmio_rd_data = '0;
        endcase
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            cycle_reg       <= '0;
            drop_reg        <= '0;
            bad_access_reg  <= 1'b0;
            mmio_q_reg      <= '0;
            rd_from_ram_reg <= 1'b0;
        end else begin
            cycle_reg       <= cycle_reg + 32'd1;
            drop_reg        <= drop_next;
            rd_from_ram_reg <= (region == REGION_RAM);
            // Out-of-range reads load zero through the MMIO path.
            mmio_q_reg      <= (region == REGION_MMIO) ? mmio_rd_data : '0;
            if (region == REGION_BAD)
                bad_access_reg <= 1'b1;
        end
    end

    // Load data is a select between two registers; the select itself is
    // registered, so q_dmem changes only at the falling edge.
    assign bus.q_dmem = rd_from_ram_reg ? ram_q_reg : mmio_q_reg;
    assign bad_access = bad_access_reg;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_mmio_responder
//   Self-checking bench: table of RAM/MMIO vectors, then hand-written
//   sequences for the FIFO, cycle counter, bad access and reset.
// ---------------------------------------------------------------------------
module tb_dmem_mmio_responder;

    localparam logic [31:0] BASE  = 32'h0000FFF0;
    localparam int          DEPTH = 4;

    logic clock;
    logic reset;
    logic bad_access;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .ADDR_BITS  (12),
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (BASE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .bad_access (bad_access)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];   // expected q_dmem per checked transaction
    logic [31:0] tx_q  [$];   // expected TX stream, in order

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        chk;
        logic [31:0] expq;
    } vec_t;

    vec_t vecs [14];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, expv);
        end
    endtask

    // One processor access per clock: drive after rising edge, sample after falling edge.
    task automatic xact(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        input logic rdy, input logic chk, input logic [31:0] expv,
                        input string name);
        logic [31:0] want;
        @(posedge clock);
        #1;
        bus.address_dmem = addr;
        bus.data         = wdata;
        bus.wren         = we;
        bus.tx_ready     = rdy;
        if (chk)
            exp_q.push_back(expv);
        if (rdy) begin
            check1({name, "_txvalid"}, bus.tx_valid, tx_q.size() != 0);
            if (bus.tx_valid && tx_q.size() != 0) begin
                check32({name, "_txdata"}, bus.tx_data, tx_q[0]);
                void'(tx_q.pop_front());
            end
        end
        if (we && addr == BASE + 32'd1 && tx_q.size() < DEPTH)
            tx_q.push_back(wdata);
        @(negedge clock);
        #1;
        if (chk) begin
            want = exp_q.pop_front();
            check32(name, bus.q_dmem, want);
        end
        $display("xact %-18s addr=%08h we=%0b data=%08h rdy=%0b q=%08h txv=%0b txd=%08h bad=%0b",
                 name, addr, we, wdata, rdy, bus.q_dmem, bus.tx_valid, bus.tx_data, bad_access);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] want;

        vecs[0]  = '{32'd5,     32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{32'd5,     32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{32'd7,     32'h22,       1'b1, 1'b0, 32'h0};
        vecs[3]  = '{32'd7,     32'h1,        1'b1, 1'b1, 32'h22};
        vecs[4]  = '{32'd7,     32'h0,        1'b0, 1'b1, 32'h1};
        vecs[5]  = '{32'hFFF,   32'hA5A5A5A5, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{32'hFFF,   32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
        vecs[7]  = '{32'd5,     32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[8]  = '{BASE + 1,  32'h0,        1'b0, 1'b1, 32'h0};
        vecs[9]  = '{BASE + 2,  32'h0,        1'b0, 1'b1, 32'h40000000};
        vecs[10] = '{BASE + 3,  32'h0,        1'b0, 1'b1, 32'h0};
        vecs[11] = '{32'd6,     32'h66,       1'b1, 1'b0, 32'h0};
        vecs[12] = '{32'd7,     32'h0,        1'b0, 1'b1, 32'h1};
        vecs[13] = '{32'd6,     32'h0,        1'b0, 1'b1, 32'h66};

        bus.address_dmem = '0;
        bus.data         = '0;
        bus.wren         = 1'b0;
        bus.tx_ready     = 1'b0;
        reset            = 1'b0;

        // Reset state
        @(negedge clock);
        #1;
        check32("rst_q", bus.q_dmem, 32'h0);
        check1("rst_txvalid", bus.tx_valid, 1'b0);
        check32("rst_txdata", bus.tx_data, 32'h0);
        check1("rst_bad", bad_access, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Table-driven RAM / MMIO accesses
        for (int i = 0; i < 14; i++) begin
            xact(vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0, vecs[i].chk, vecs[i].expq,
                 $sformatf("vec%0d", i));
            check1($sformatf("vec%0d_bad", i), bad_access, 1'b0);
        end

        // FIFO fill with consumer stalled; fifth push is dropped
        for (int i = 1; i <= 5; i++) begin
            xact(BASE + 1, 32'(i), 1'b1, 1'b0, 1'b1, 32'h0, "txdata_push");
            if (i == 1) begin
                check1("push_empty_valid", bus.tx_valid, 1'b1);
                check32("push_empty_head", bus.tx_data, 32'h1);
            end
        end
        xact(BASE + 2, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80000004, "status_full");
        xact(BASE + 3, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1,        "drop_one");
        check32("hold_head", bus.tx_data, 32'h1);

        // Push while full with simultaneous pop is accepted
        xact(BASE + 1, 32'h9, 1'b1, 1'b1, 1'b1, 32'h0, "push_pop_full");
        check32("head_adv", bus.tx_data, 32'h2);
        xact(BASE + 2, 32'h0, 1'b0, 1'b0, 1'b1, 32'h80000004, "status_still_full");
        xact(BASE + 3, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1,        "drop_unchanged");

        // Drain while reading STATUS (pre-edge counts)
        xact(BASE + 2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80000004, "drain_st4");
        xact(BASE + 2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000003, "drain_st3");
        xact(BASE + 2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000002, "drain_st2");
        xact(BASE + 2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000001, "drain_st1");
        xact(BASE + 2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40000000, "pop_empty");
        xact(BASE + 2, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40000000, "status_empty");

        // DROP write clears; STATUS write ignored
        xact(BASE + 3, 32'h0,        1'b1, 1'b0, 1'b1, 32'h1,        "drop_clr");
        xact(BASE + 3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        "drop_cleared");
        xact(BASE + 2, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h40000000, "status_wr");
        xact(BASE + 2, 32'h0,        1'b0, 1'b0, 1'b1, 32'h40000000, "status_after_wr");

        // Cycle counter: edge k after release reads k-1
        @(posedge clock);
        #1;
        reset = 1'b0;
        tx_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++)
            xact(32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "idle");
        xact(BASE, 32'h0, 1'b0, 1'b0, 1'b1, 32'd9,  "cycle_e10");
        xact(BASE, 32'h0, 1'b0, 1'b0, 1'b1, 32'd10, "cycle_e11");

        // Wrap: preload the counter to all-ones
        @(posedge clock);
        #1;
        bus.address_dmem = BASE;
        bus.wren         = 1'b0;
        exp_q.push_back(32'hFFFFFFFF);
        force dut.cycle_reg = 32'hFFFFFFFF;
        release dut.cycle_reg;
        @(negedge clock);
        #1;
        want = exp_q.pop_front();
        check32("cycle_max", bus.q_dmem, want);
        xact(BASE, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, "cycle_wrap");

        // Bad access, sticky flag, reset with FIFO occupied
        xact(BASE + 1,       32'hAA,   1'b1, 1'b0, 1'b1, 32'h0,        "push_aa");
        xact(32'h00010000,   32'h0,    1'b0, 1'b0, 1'b1, 32'h0,        "bad_rd");
        check1("bad_set", bad_access, 1'b1);
        xact(32'h00001005,   32'h1234, 1'b1, 1'b0, 1'b1, 32'h0,        "bad_wr");
        xact(32'd5,          32'h0,    1'b0, 1'b0, 1'b1, 32'hDEADBEEF, "ram5_no_alias");
        check1("bad_sticky", bad_access, 1'b1);
        check1("pre_rst_valid", bus.tx_valid, 1'b1);

        @(posedge clock);
        #1;
        reset            = 1'b0;
        bus.address_dmem = 32'd5;
        bus.data         = 32'h0;
        bus.wren         = 1'b1;   // store lost while in reset
        #1;
        check32("mid_rst_q", bus.q_dmem, 32'h0);
        check1("mid_rst_bad", bad_access, 1'b0);
        check1("mid_rst_valid", bus.tx_valid, 1'b0);
        check32("mid_rst_txdata", bus.tx_data, 32'h0);
        tx_q.delete();
        @(negedge clock);
        @(posedge clock);
        #1;
        bus.wren = 1'b0;
        reset    = 1'b1;
        xact(32'd5,    32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, "ram5_after_rst");
        check1("bad_after_rst", bad_access, 1'b0);
        xact(BASE + 2, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40000000, "status_after_rst");
        xact(BASE + 3, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0,        "drop_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
